// File: rtl/frame_capture_pkg.sv
// Shared types and constants for the frame capture stage that feeds the 3x3 convolution filter.
package frame_capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } cap_state_t;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    // Counter width for an extent of n; a single-entry extent still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_position_counter.sv
// Raster (row, col) position tracker; the column is the fast index and wraps into the row.
module raster_position_counter
    import frame_capture_pkg::*;
#(
    parameter int H = 4,
    parameter int V = 4,
    localparam int RW = cnt_width(H),
    localparam int CW = cnt_width(V)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [RW-1:0] o_row,
    output logic [CW-1:0] o_col,
    output logic          o_last
);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [RW-1:0] w_base_row;
    logic [CW-1:0] w_base_col;
    logic [RW-1:0] w_next_row;
    logic [CW-1:0] w_next_col;

    // Clear and advance together yield the successor of (0,0), used for an early restart.
    always_comb begin
        w_base_row = i_clear ? '0 : r_row;
        w_base_col = i_clear ? '0 : r_col;
        w_next_row = w_base_row;
        w_next_col = w_base_col;
        if (i_advance) begin
            if (w_base_col == CW'(V - 1)) begin
                w_next_col = '0;
                if (w_base_row == RW'(H - 1)) begin
                    w_next_row = '0;
                end else begin
                    w_next_row = w_base_row + RW'(1);
                end
            end else begin
                w_next_col = w_base_col + CW'(1);
                w_next_row = w_base_row;
            end
        end else begin
            w_next_row = w_base_row;
            w_next_col = w_base_col;
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else begin
            r_row <= w_next_row;
            r_col <= w_next_col;
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == RW'(H - 1)) && (r_col == CW'(V - 1));

endmodule

// File: rtl/frame_capture.sv
// Assembles a raster-order RGB stream into a held [ch][row][col] frame with SOF error recovery.
module frame_capture
    import frame_capture_pkg::*;
#(
    parameter int H = 4,
    parameter int V = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_s_valid,
    output logic                           o_s_ready,
    input  logic [23:0]                    i_s_data,
    input  logic                           i_s_sof,
    output logic [0:2][0:H-1][0:V-1][7:0]  o_image,
    output logic                           o_frame_valid,
    input  logic                           i_frame_ack,
    output logic                           o_sof_err
);

    localparam int RW     = cnt_width(H);
    localparam int CW     = cnt_width(V);
    localparam bit SINGLE = (H * V == 1);

    cap_state_t                    r_state;
    logic                          r_frame_valid;
    logic                          r_sof_err;
    logic [0:2][0:H-1][0:V-1][7:0] r_image;

    logic          w_accept;
    logic          w_write;
    logic          w_early;
    logic          w_err;
    logic          w_clear;
    logic          w_advance;
    logic          w_wr_last;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col;
    logic          w_last;
    logic [RW-1:0] w_wr_row;
    logic [CW-1:0] w_wr_col;

    raster_position_counter #(.H(H), .V(V)) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last)
    );

    assign o_s_ready = (r_state != HOLD);
    assign w_accept  = i_s_valid & o_s_ready;

    // Write/position decode; in IDLE the counter already sits at (0,0).
    always_comb begin
        w_write   = 1'b0;
        w_early   = 1'b0;
        w_err     = 1'b0;
        w_clear   = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && i_s_sof) begin
                    w_write   = 1'b1;
                    w_advance = 1'b1;
                end else begin
                    w_err = w_accept;
                end
            end
            FILL: begin
                if (w_accept) begin
                    w_write   = 1'b1;
                    w_advance = 1'b1;
                    if (i_s_sof && ((w_row != '0) || (w_col != '0))) begin
                        w_early = 1'b1;
                        w_err   = 1'b1;
                        w_clear = 1'b1;
                    end else begin
                        w_early = 1'b0;
                    end
                end else begin
                    w_write = 1'b0;
                end
            end
            HOLD: begin
                if (i_frame_ack) begin
                    w_clear = 1'b1;
                end else begin
                    w_clear = 1'b0;
                end
            end
            default: begin
                w_clear = 1'b1;
            end
        endcase
        w_wr_row  = w_early ? '0 : w_row;
        w_wr_col  = w_early ? '0 : w_col;
        w_wr_last = w_early ? SINGLE : w_last;
    end

    // Capture FSM with registered frame_valid and sof_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_frame_valid <= 1'b0;
            r_sof_err     <= 1'b0;
        end else begin
            r_sof_err <= w_err;
            case (r_state)
                IDLE, FILL: begin
                    if (w_write && w_wr_last) begin
                        r_state       <= HOLD;
                        r_frame_valid <= 1'b1;
                    end else if (w_write) begin
                        r_state       <= FILL;
                        r_frame_valid <= 1'b0;
                    end else begin
                        r_state       <= r_state;
                        r_frame_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (i_frame_ack) begin
                        r_state       <= IDLE;
                        r_frame_valid <= 1'b0;
                    end else begin
                        r_state       <= HOLD;
                        r_frame_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_frame_valid <= 1'b0;
                end
            endcase
        end
    end

    // Image array; abandoned partial frames are deliberately left in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_image <= '0;
        end else if (w_write) begin
            r_image[CH_R][w_wr_row][w_wr_col] <= i_s_data[R_MSB:R_LSB];
            r_image[CH_G][w_wr_row][w_wr_col] <= i_s_data[G_MSB:G_LSB];
            r_image[CH_B][w_wr_row][w_wr_col] <= i_s_data[B_MSB:B_LSB];
        end
    end

    assign o_image       = r_image;
    assign o_frame_valid = r_frame_valid;
    assign o_sof_err     = r_sof_err;

endmodule
